// File: rtl/uv_array_pkg.sv
// Shared types and helpers for the uv_array u/v counter-pair model.
// Holds the monitor state encoding, default counter width and index-width helper.
package uv_array_pkg;

  typedef enum logic {
    MON_RUN  = 1'b0,
    MON_FAIL = 1'b1
  } mon_state_e;

  localparam int DEFAULT_CNT_W = 16;

  // Select/index width for n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uv_array_channel.sv
// One u/v register pair: load has priority over advance, and a local bad flag
// reports (u + v) mod 2^WIDTH == STEP on the current register state.
module uv_channel
  import uv_array_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             ld_i,
  input  logic [WIDTH-1:0] ld_u_i,
  input  logic [WIDTH-1:0] ld_v_i,
  output logic [WIDTH-1:0] u_o,
  output logic [WIDTH-1:0] v_o,
  output logic             bad_o
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] u_q, u_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH-1:0] sum;

  always_comb begin
    u_d = u_q;
    v_d = v_q;
    if (ld_i) begin
      u_d = ld_u_i;
      v_d = ld_v_i;
    end else if (en_i) begin
      u_d = (u_q < v_q) ? (u_q + v_q) : (v_q + STEP_W);
      v_d = v_q + STEP_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_q <= STEP_W;
      v_q <= STEP_W;
    end else begin
      u_q <= u_d;
      v_q <= v_d;
    end
  end

  assign sum   = u_q + v_q;
  assign bad_o = (sum == STEP_W);
  assign u_o   = u_q;
  assign v_o   = v_q;

endmodule

// File: rtl/uv_array.sv
// Multi-channel u/v counter array with a sticky invariant monitor.
// Define UV_ARRAY_ASSERT_EN to compile in per-channel assertions and a fail cover.
module uv_array
  import uv_array_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 2,
  parameter int STEP     = 1,
  parameter int CNT_W    = DEFAULT_CNT_W,
  localparam int IDX_W   = idx_w(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                ld,
  input  logic [IDX_W-1:0]    ld_ch,
  input  logic [WIDTH-1:0]    ld_u,
  input  logic [WIDTH-1:0]    ld_v,
  input  logic [IDX_W-1:0]    obs_sel,
  output logic [WIDTH-1:0]    u_obs,
  output logic [WIDTH-1:0]    v_obs,
  output logic [CHANNELS-1:0] viol,
  output logic                fail,
  output logic [IDX_W-1:0]    fail_ch,
  output logic [CNT_W-1:0]    fail_cyc
);

  logic [WIDTH-1:0]    u_arr [CHANNELS];
  logic [WIDTH-1:0]    v_arr [CHANNELS];
  logic [CHANNELS-1:0] bad;
  logic [CHANNELS-1:0] ld_hit;

  // Out-of-range ld_ch values match no channel, so such loads fall away.
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign ld_hit[gi] = ld && (ld_ch == IDX_W'(gi));

      uv_channel #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
      ) u_channel (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en[gi]),
        .ld_i   (ld_hit[gi]),
        .ld_u_i (ld_u),
        .ld_v_i (ld_v),
        .u_o    (u_arr[gi]),
        .v_o    (v_arr[gi]),
        .bad_o  (bad[gi])
      );
    end
  endgenerate

  mon_state_e          state_q, state_d;
  logic [CHANNELS-1:0] viol_q;
  logic [IDX_W-1:0]    fail_ch_q, fail_ch_d;
  logic [CNT_W-1:0]    fail_cyc_q, fail_cyc_d;
  logic [CNT_W-1:0]    cyc_q;
  logic [IDX_W-1:0]    first_bad;

  always_comb begin
    first_bad = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (bad[i]) first_bad = IDX_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    fail_ch_d  = fail_ch_q;
    fail_cyc_d = fail_cyc_q;
    case (state_q)
      MON_RUN: begin
        if (|bad) begin
          state_d    = MON_FAIL;
          fail_ch_d  = first_bad;
          fail_cyc_d = cyc_q;
        end
      end
      MON_FAIL: state_d = MON_FAIL;
      default:  state_d = MON_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MON_RUN;
      fail_ch_q  <= '0;
      fail_cyc_q <= '0;
      viol_q     <= '0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      fail_ch_q  <= fail_ch_d;
      fail_cyc_q <= fail_cyc_d;
      viol_q     <= viol_q | bad;
      if (cyc_q != '1) cyc_q <= cyc_q + 1'b1;
    end
  end

  // Unselected or out-of-range observation reads as zero.
  always_comb begin
    u_obs = '0;
    v_obs = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (obs_sel == IDX_W'(i)) begin
        u_obs = u_arr[i];
        v_obs = v_arr[i];
      end
    end
  end

  assign viol     = viol_q;
  assign fail     = (state_q == MON_FAIL);
  assign fail_ch  = fail_ch_q;
  assign fail_cyc = fail_cyc_q;

`ifdef UV_ARRAY_ASSERT_EN
  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_prop
      always @* begin
        prop_i: assert (!bad[gi]);
      end
    end
  endgenerate

  always @* begin
    cov_fail: cover (fail);
    prop_fail_viol: assert (!fail || viol_q[fail_ch_q]);
  end
`endif

endmodule

// File: tb/tb_uv_array.sv
// Randomized scoreboard bench for uv_array (3 channels, so out-of-range
// load and observe selects are exercised) against an arithmetic model.
module tb_uv_array;

  localparam int W     = 4;
  localparam int CH    = 3;
  localparam int STEP  = 1;
  localparam int CNT_W = 16;
  localparam int M     = 1 << W;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [CH-1:0] en = '0;
  logic          ld = 1'b0;
  logic [1:0]    ld_ch = '0;
  logic [W-1:0]  ld_u = '0, ld_v = '0;
  logic [1:0]    obs_sel = '0;
  logic [W-1:0]  u_obs, v_obs;
  logic [CH-1:0] viol;
  logic          fail;
  logic [1:0]    fail_ch;
  logic [CNT_W-1:0] fail_cyc;

  uv_array #(.WIDTH(W), .CHANNELS(CH), .STEP(STEP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .ld(ld), .ld_ch(ld_ch), .ld_u(ld_u),
    .ld_v(ld_v), .obs_sel(obs_sel), .u_obs(u_obs), .v_obs(v_obs),
    .viol(viol), .fail(fail), .fail_ch(fail_ch), .fail_cyc(fail_cyc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int u, v, viol, fail, fail_ch, fail_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: plain integers with explicit modular arithmetic.
  int m_u[CH], m_v[CH];
  int m_viol, m_fail, m_fail_ch, m_fail_cyc, m_cyc;

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_u[i] = STEP % M;
      m_v[i] = STEP % M;
    end
    m_viol = 0; m_fail = 0; m_fail_ch = 0; m_fail_cyc = 0; m_cyc = 0;
  endtask

  task automatic model_edge(input int r, input int e, input int l, input int lc,
                            input int lu, input int lv);
    int first;
    if (r != 0) begin
      model_reset();
      return;
    end
    first = -1;
    for (int i = 0; i < CH; i++) begin
      if ((m_u[i] + m_v[i]) % M == STEP % M) begin
        m_viol |= (1 << i);
        if (first < 0) first = i;
      end
    end
    if (m_fail == 0 && first >= 0) begin
      m_fail = 1; m_fail_ch = first; m_fail_cyc = m_cyc;
    end
    if (m_cyc < CMAX) m_cyc++;
    for (int i = 0; i < CH; i++) begin
      if (l != 0 && lc == i) begin
        m_u[i] = lu; m_v[i] = lv;
      end else if (((e >> i) & 1) != 0) begin
        m_u[i] = (m_u[i] < m_v[i]) ? (m_u[i] + m_v[i]) % M : (m_v[i] + STEP) % M;
        m_v[i] = (m_v[i] + STEP) % M;
      end
    end
  endtask

  task automatic step(input int r, input int e, input int l, input int lc,
                      input int lu, input int lv, input int os);
    exp_t x;
    @(negedge clk);
    rst = (r != 0); en = CH'(e); ld = (l != 0); ld_ch = 2'(lc);
    ld_u = W'(lu); ld_v = W'(lv); obs_sel = 2'(os);
    model_edge(r, e, l, lc, lu, lv);
    x.u = (os < CH) ? m_u[os] : 0;
    x.v = (os < CH) ? m_v[os] : 0;
    x.viol = m_viol; x.fail = m_fail; x.fail_ch = m_fail_ch; x.fail_cyc = m_fail_cyc;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Monitor: one transaction per clock, popped just after the active edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("u_obs", int'(u_obs), x.u);
        chk("v_obs", int'(v_obs), x.v);
        chk("viol", int'(viol), x.viol);
        chk("fail", int'(fail), x.fail);
        chk("fail_ch", int'(fail_ch), x.fail_ch);
        chk("fail_cyc", int'(fail_cyc), x.fail_cyc);
        $display("[TB] t=%0t u=%0d v=%0d viol=%b fail=%0d ch=%0d cyc=%0d",
                 $time, u_obs, v_obs, viol, fail, fail_ch, fail_cyc);
      end
    end
  end

  initial begin
    int wait_cnt;
    model_reset();
    // Reset then idle
    repeat (2) step(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 5; c++) step(0, 0, 0, 0, 0, 0, c % 4);
    // Lockstep advance through the wrap
    for (int c = 0; c < 20; c++) step(0, 7, 0, 0, 0, 0, c % 3);
    // Bad load on ch0 at cycle 10 after reset
    step(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 10; c++) step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 1, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0, 0);
    // rst mid-failure
    step(1, 0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 2; c++) step(0, 0, 0, 0, 0, 0, 1);
    // Staggered bad loads: ch1 first, then ch0
    step(0, 0, 1, 1, 3, 14, 1);
    step(0, 0, 1, 0, 1, 0, 0);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0, 0, 0);
    // Wrap-sum load is not a violation, nor is one advance from it
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 8, 8, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    // Out-of-range load and observe
    step(0, 0, 1, 3, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 3);
    // Randomized phase with occasional resets
    for (int c = 0; c < 600; c++) begin
      step(($urandom_range(0, 39) == 0) ? 1 : 0,
           int'($urandom_range(0, 7)),
           ($urandom_range(0, 7) == 0) ? 1 : 0,
           int'($urandom_range(0, 3)),
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, M - 1)),
           int'($urandom_range(0, 3)));
    end
    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #2;
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uv_array.md
# uv_array

Parametrised multi-channel generalisation of the u/v counter-pair benchmark for the formal flow. It holds CHANNELS independent u/v register pairs of WIDTH bits that advance by a configurable STEP, and accepts direct state loads for fault injection. A monitor FSM checks each pair against the invariant (u + v) != STEP, latches sticky per-channel violations, and records the first failing channel and cycle. It serves as a scalable model-checking sample and as its own simulation self-check.

## Interface
- WIDTH, 4, bit width of each u and v register.
- CHANNELS, 2, number of u/v pairs (≥1).
- STEP, 1, increment constant, taken mod 2^WIDTH.
- CNT_W, 16, width of the cycle counter and fail_cyc.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  CHANNELS  per-channel advance enable.
- ld  in  1  load strobe.
- ld_ch  in  max(1,$clog2(CHANNELS))  channel to load.
- ld_u, ld_v  in  WIDTH each  load values.
- obs_sel  in  max(1,$clog2(CHANNELS))  observed channel.
- u_obs, v_obs  out  WIDTH each  u/v of channel obs_sel.
- viol  out  CHANNELS  sticky per-channel violation flags.
- fail  out  1  monitor in FAIL state.
- fail_ch  out  max(1,$clog2(CHANNELS))  first failing channel.
- fail_cyc  out  CNT_W  cycle count at first failure.

## Operation
- Per channel i, priority rst > load > advance > hold.
  - Load: ld && ld_ch==i sets u<=ld_u, v<=ld_v (en[i] ignored).
  - Advance: en[i] sets u <= (u < v) ? u+v : v+STEP and v <= v+STEP. Comparison is unsigned; sums wrap mod 2^WIDTH.
  - Otherwise u and v hold.
- ld with ld_ch ≥ CHANNELS is ignored.
- bad[i] = ((u_i + v_i) mod 2^WIDTH == STEP mod 2^WIDTH), evaluated on current register state.
- viol[i] <= viol[i] | bad[i]; cleared only by rst.
- cyc: internal CNT_W counter, 0 at reset, +1 per cycle, saturates at all-ones.
- Monitor FSM has two states.
  - MON_RUN: on any bad[i], capture fail_ch = lowest i with bad[i] and fail_cyc = cyc, then go to MON_FAIL.
  - MON_FAIL: absorbing until rst; fail_ch and fail_cyc are frozen.
- u_obs and v_obs are a combinational mux of the selected channel. They read 0 when obs_sel ≥ CHANNELS.
- Unloaded runs never violate: u == v always, so the sum is 2v.

## Timing
- Reset values: u = v = STEP mod 2^WIDTH in every channel; viol = 0, fail = 0, fail_ch = 0, fail_cyc = 0, cyc = 0; u_obs and v_obs read STEP.
- Load or advance: visible on u_obs/v_obs one cycle after the strobe edge.
- Violation latency: bad state present in cycle t gives viol/fail asserted from t+1. Total from a bad load strobe is 2 edges.
- Simultaneous bad on several channels: all matching viol bits set; fail_ch takes the lowest index.
- rst mid-failure: all state returns to reset values at that edge.

## Configuration
- Macro UV_ARRAY_ASSERT_EN.
- Defined: compiles in an immediate assertion prop_i: assert(!bad[i]) per channel in always @*.
  - Also compiles in cover(fail) and an assertion that fail implies viol[fail_ch].
  - The formal flow targets these.
- Undefined: no assertions. Violations are reported only through viol, fail, fail_ch and fail_cyc; functional behaviour is identical.

## Structure
- Package uv_array_pkg holds:
  - the monitor state typedef enum {MON_RUN, MON_FAIL};
  - the default CNT_W constant;
  - a helper function for index width, max(1,$clog2(n)).
- Sub-module uv_channel: one u/v pair with load/advance logic and a local bad output. It is instantiated CHANNELS times by a generate loop.
- The top level holds the monitor FSM, cycle counter, priority encoder and observation mux.

## Test plan
- Reset then idle, W=4, STEP=1, en=0 for 5 cycles -> u_obs = v_obs = 1; viol=0; fail=0.
- en=2'b11 for 20 cycles -> u=v tracks 1,2,…,15,0,… (wrap after 15); fail stays 0 throughout.
- ld ch0 u=0, v=1 at cycle 10 -> u_obs=0/v_obs=1 at cycle 11; viol=2'b01, fail=1, fail_ch=0, fail_cyc=11 at cycle 12.
- Load ch1 u=3, v=14 (sum 17 mod 16 = 1), then ch0 u=1, v=0 on the next cycle -> viol[1] set first, fail_ch=1; viol[0] sets one cycle later; fail_ch stays 1.
- Load ch0 with u=v=8 (sum 0, not bad), then advance one step -> viol stays 0. Confirms wrap arithmetic is not flagged.
- rst asserted while fail=1 -> next cycle all outputs back to reset values; cyc restarts at 0.
